// File: rtl/lstm_pkg.sv
// Shared Q16.16 types, LSTM geometry and the 32-bit saturation helper
// for the gate pre-activation datapath.
package lstm_pkg;

    localparam int unsigned FRAC_BITS = 16;
    localparam int unsigned HIDDEN    = 100;
    localparam int unsigned GATES     = 4;
    localparam int unsigned ROWS      = GATES * HIDDEN;
    localparam int unsigned COLS      = 2 * HIDDEN;

    typedef logic signed [31:0] fix_t;
    typedef logic signed [63:0] acc_t;

    localparam acc_t SAT_MAX = 64'sh0000_0000_7FFF_FFFF;
    localparam acc_t SAT_MIN = 64'shFFFF_FFFF_8000_0000;

    // Clamp a wide signed value into the 32-bit fixed-point range.
    function automatic fix_t sat32(input acc_t v);
        if (v > SAT_MAX) begin
            return fix_t'(32'h7FFF_FFFF);
        end else if (v < SAT_MIN) begin
            return fix_t'(32'h8000_0000);
        end else begin
            return fix_t'(v[31:0]);
        end
    endfunction

endpackage

// File: rtl/fix_mac_sat.sv
// One multiply-accumulate step plus the end-of-row bias align, floor rescale
// and saturation; purely combinational.
module fix_mac_sat
    import lstm_pkg::*;
#(
    parameter int unsigned FRAC = FRAC_BITS
) (
    input  acc_t acc,
    input  fix_t w,
    input  fix_t x,
    input  fix_t bias,
    input  logic last,
    output acc_t next_acc_c,
    output fix_t row_result_c
);

    acc_t prod_c;
    acc_t sum_c;
    acc_t scaled_c;

    // Full 64-bit signed product; >>> on a signed operand floors toward -inf.
    always_comb begin
        prod_c       = acc_t'(w) * acc_t'(x);
        sum_c        = acc + prod_c;
        scaled_c     = (sum_c + (acc_t'(bias) <<< FRAC)) >>> FRAC;
        next_acc_c   = last ? '0 : sum_c;
        row_result_c = sat32(scaled_c);
    end

endmodule

// File: rtl/lstm_gate_preact_mac.sv
// Gate pre-activation engine: z = W*[x;h_prev] + b in Q16.16, one streamed
// weight word per cycle, results held in a register array until the next pass.
module lstm_gate_preact_mac #(
    parameter int unsigned ROWS = lstm_pkg::ROWS,
    parameter int unsigned COLS = lstm_pkg::COLS,
    parameter int unsigned FRAC = lstm_pkg::FRAC_BITS
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic signed [31:0] xh   [COLS],
    input  logic signed [31:0] bias [ROWS],
    input  logic               w_valid,
    input  logic signed [31:0] w_data,
    output logic               w_ready,
    output logic signed [31:0] z    [ROWS],
    output logic               busy,
    output logic               done
);

    localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic             w_ready_nxt;
    logic             busy_nxt;
    logic             done_nxt;

    logic [RW-1:0]    row;
    logic [CW-1:0]    col;
    lstm_pkg::acc_t   acc;
    lstm_pkg::acc_t   next_acc_c;
    lstm_pkg::fix_t   row_result_c;
    lstm_pkg::fix_t   xh_reg   [COLS];
    lstm_pkg::fix_t   bias_reg [ROWS];

    logic             hs_c;
    logic             last_col_c;
    logic             last_row_c;
    logic             start_ok_c;

    assign hs_c       = w_valid & w_ready;
    assign last_col_c = (col == CW'(COLS - 1));
    assign last_row_c = (row == RW'(ROWS - 1));
    assign start_ok_c = start & (state == S_IDLE);

    fix_mac_sat #(
        .FRAC (FRAC)
    ) u_mac (
        .acc          (acc),
        .w            (w_data),
        .x            (xh_reg[col]),
        .bias         (bias_reg[row]),
        .last         (last_col_c),
        .next_acc_c   (next_acc_c),
        .row_result_c (row_result_c)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            w_ready <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            w_ready <= w_ready_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
        end
    end

    // Handshake flags are registered from the next state so they track it exactly.
    always_comb begin
        state_nxt   = state;
        w_ready_nxt = 1'b0;
        busy_nxt    = 1'b0;
        done_nxt    = 1'b0;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (hs_c && last_col_c && last_row_c) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        w_ready_nxt = (state_nxt == S_RUN);
        busy_nxt    = (state_nxt != S_IDLE);
        done_nxt    = (state_nxt == S_DONE);
    end

    // Operand latches, counters, accumulator and the per-row result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc <= '0;
            row <= '0;
            col <= '0;
            for (int unsigned i = 0; i < ROWS; i++) begin
                z[i] <= '0;
            end
        end else if (start_ok_c) begin
            xh_reg   <= xh;
            bias_reg <= bias;
            acc      <= '0;
            row      <= '0;
            col      <= '0;
        end else if (hs_c) begin
            acc <= next_acc_c;
            if (last_col_c) begin
                z[row] <= row_result_c;
                row    <= row + RW'(1);
                col    <= '0;
            end else begin
                col <= col + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_lstm_gate_preact_mac.sv
// Bench for lstm_gate_preact_mac: a 4x3 instance checked every cycle against a
// queue-based reference model, and a full-size instance for the reset/latency case.
module tb_lstm_gate_preact_mac;

    localparam int unsigned RA = 4;
    localparam int unsigned CA = 3;
    localparam int unsigned NA = RA * CA;
    localparam int unsigned RB = 400;
    localparam int unsigned CB = 200;
    localparam logic signed [31:0] ONE = 32'sh0001_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int unsigned edge_n = 0;

    logic               rst_a = 1'b0;
    logic               a_start = 1'b0;
    logic               a_w_valid = 1'b0;
    logic signed [31:0] a_w_data = '0;
    logic signed [31:0] a_xh [CA];
    logic signed [31:0] a_bias [RA];
    logic               a_w_ready;
    logic signed [31:0] a_z [RA];
    logic               a_busy;
    logic               a_done;

    logic               rst_b = 1'b0;
    logic               b_start = 1'b0;
    logic               b_w_valid = 1'b0;
    logic signed [31:0] b_w_data = '0;
    logic signed [31:0] b_xh [CB];
    logic signed [31:0] b_bias [RB];
    logic               b_w_ready;
    logic signed [31:0] b_z [RB];
    logic               b_busy;
    logic               b_done;

    lstm_gate_preact_mac #(.ROWS(RA), .COLS(CA), .FRAC(16)) dut_a (
        .clk(clk), .rst_n(rst_a), .start(a_start), .xh(a_xh), .bias(a_bias),
        .w_valid(a_w_valid), .w_data(a_w_data), .w_ready(a_w_ready),
        .z(a_z), .busy(a_busy), .done(a_done)
    );

    lstm_gate_preact_mac dut_b (
        .clk(clk), .rst_n(rst_b), .start(b_start), .xh(b_xh), .bias(b_bias),
        .w_valid(b_w_valid), .w_data(b_w_data), .w_ready(b_w_ready),
        .z(b_z), .busy(b_busy), .done(b_done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Row result from the arithmetic rules: add aligned bias, floor-divide by 2^16, clamp.
    function automatic logic signed [31:0] ref_row(input longint dot, input logic signed [31:0] b);
        longint s;
        longint q;
        s = dot + longint'(b) * 64'sd65536;
        q = s / 64'sd65536;
        if ((s % 64'sd65536) != 0 && s < 0) q = q - 1;
        if (q > 64'sd2147483647) return 32'sh7FFF_FFFF;
        if (q < -64'sd2147483648) return 32'sh8000_0000;
        return 32'(q);
    endfunction

    // Reference model for the small instance: weights accepted this pass are queued.
    logic signed [31:0] m_xh [CA];
    logic signed [31:0] m_bias [RA];
    logic signed [31:0] m_z [RA];
    logic signed [31:0] m_wq [$];
    bit                 m_busy = 1'b0;
    bit                 m_ready = 1'b0;
    bit                 m_done = 1'b0;
    int unsigned        m_start_edge = 0;
    int                 m_r;
    longint             m_dot;

    initial forever begin
        @(posedge clk);
        edge_n++;
        if (rst_a !== 1'b1) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            foreach (m_z[i]) m_z[i] = '0;
        end else if (m_done) begin
            m_done = 1'b0;
            m_busy = 1'b0;
        end else if (m_busy) begin
            if (a_w_valid) begin
                m_wq.push_back(a_w_data);
                if ((m_wq.size() % CA) == 0) begin
                    m_r   = m_wq.size() / CA - 1;
                    m_dot = 0;
                    for (int k = 0; k < CA; k++) begin
                        m_dot += longint'(m_wq[m_r * CA + k]) * longint'(m_xh[k]);
                    end
                    m_z[m_r] = ref_row(m_dot, m_bias[m_r]);
                    if (m_r == RA - 1) m_done = 1'b1;
                end
            end
        end else if (a_start) begin
            m_xh   = a_xh;
            m_bias = a_bias;
            m_wq.delete();
            m_busy = 1'b1;
            m_start_edge = edge_n;
        end
        m_ready = m_busy && !m_done;
    end

    bit a_chk_en = 1'b0;
    int a_done_cnt = 0;
    int a_done_cyc = 0;

    initial forever begin
        @(negedge clk);
        if (a_chk_en) begin
            check("a_busy", a_busy, m_busy);
            check("a_w_ready", a_w_ready, m_ready);
            check("a_done", a_done, m_done);
            for (int i = 0; i < RA; i++) check($sformatf("a_z[%0d]", i), a_z[i], m_z[i]);
            if (a_done === 1'b1) begin
                a_done_cnt++;
                a_done_cyc = int'(edge_n - m_start_edge) + 2;
            end
        end
    end

    logic signed [31:0] s_xh [CA];
    logic signed [31:0] s_bias [RA];
    logic signed [31:0] s_w [NA];

    function automatic logic signed [31:0] rnd_small();
        return 32'(int'($urandom_range(33554431)) - 16777216);
    endfunction

    // One small pass; exp_cyc > 0 also pins the done cycle (start cycle counts as 1).
    task automatic run_a(input int duty, input bit poke, input int exp_cyc);
        int idx;
        int guard;
        bit hs;
        bit poked;
        idx = 0;
        guard = 0;
        poked = 1'b0;
        a_done_cnt = 0;
        a_done_cyc = 0;
        a_xh = s_xh;
        a_bias = s_bias;
        a_start = 1'b1;
        a_w_valid = 1'b0;
        tick();
        a_start = 1'b0;
        foreach (a_xh[i]) a_xh[i] = $urandom;
        foreach (a_bias[i]) a_bias[i] = $urandom;
        while (idx < NA && guard < 400) begin
            a_w_valid = (duty >= 100) || ($urandom_range(99) < duty);
            a_w_data = a_w_valid ? s_w[idx] : 32'($urandom);
            if (poke && !poked && idx == NA / 2) begin
                a_start = 1'b1;
                poked = 1'b1;
            end
            hs = a_w_valid && (a_w_ready === 1'b1);
            tick();
            a_start = 1'b0;
            if (hs) idx++;
            guard++;
        end
        check("a_words_accepted", idx, NA);
        a_w_valid = 1'b1;
        a_w_data = $urandom;
        repeat (4) tick();
        a_w_valid = 1'b0;
        check("a_done_pulses", a_done_cnt, 1);
        if (exp_cyc > 0) check("a_done_cycle", a_done_cyc, exp_cyc);
    endtask

    task automatic load_identity();
        s_xh = '{ONE, 2 * ONE, 3 * ONE};
        s_bias = '{0, 0, 0, 0};
        s_w = '{ONE, 0, 0, 0, ONE, 0, 0, 0, ONE, ONE, ONE, ONE};
    endtask

    task automatic check_identity(input string tag);
        check({tag, "_z0"}, a_z[0], 32'h0001_0000);
        check({tag, "_z1"}, a_z[1], 32'h0002_0000);
        check({tag, "_z2"}, a_z[2], 32'h0003_0000);
        check({tag, "_z3"}, a_z[3], 32'h0006_0000);
    endtask

    task automatic run_small();
        foreach (a_xh[i]) a_xh[i] = '0;
        foreach (a_bias[i]) a_bias[i] = '0;
        rst_a = 1'b0;
        repeat (2) tick();
        a_chk_en = 1'b1;
        rst_a = 1'b1;
        tick();
        check("a_reset_z0", a_z[0], 32'h0);
        check("a_reset_busy", a_busy, 1'b0);

        load_identity();
        run_a(100, 1'b0, 14);
        check_identity("ident");

        s_xh = '{32'shFFFF_8000, ONE, 0};
        s_bias = '{32'sh0000_4000, rnd_small(), rnd_small(), rnd_small()};
        s_w = '{2 * ONE, ONE, 5 * ONE, rnd_small(), rnd_small(), rnd_small(),
                rnd_small(), rnd_small(), rnd_small(), rnd_small(), rnd_small(), rnd_small()};
        run_a(100, 1'b0, 14);
        check("bias_neg_z0", a_z[0], 32'h0000_4000);

        s_xh = '{32'sh0000_0001, 0, 0};
        s_bias = '{0, 0, 0, 0};
        s_w = '{-32'sh0000_8000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        run_a(100, 1'b0, 14);
        check("floor_z0", a_z[0], 32'hFFFF_FFFF);

        s_xh = '{32'sh7FFF_FFFF, 32'sh7FFF_FFFF, 0};
        s_w = '{32'sh7FFF_FFFF, 32'sh7FFF_FFFF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        run_a(100, 1'b0, 14);
        check("sat_pos_z0", a_z[0], 32'h7FFF_FFFF);
        s_w = '{32'sh8000_0001, 32'sh8000_0001, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        run_a(100, 1'b0, 14);
        check("sat_neg_z0", a_z[0], 32'h8000_0000);

        load_identity();
        run_a(30, 1'b1, 0);
        check_identity("stall");

        for (int p = 0; p < 4; p++) begin
            foreach (s_xh[i]) s_xh[i] = rnd_small();
            foreach (s_bias[i]) s_bias[i] = rnd_small();
            foreach (s_w[i]) s_w[i] = rnd_small();
            run_a(int'($urandom_range(100, 50)), p[0], 0);
        end
    endtask

    function automatic logic signed [31:0] wb(input int r, input int k);
        return 32'((((r * 31 + k * 17) % 23) - 11) * 16384);
    endfunction

    logic signed [31:0] exp_b [RB];

    task automatic run_big();
        int idx;
        int guard;
        int done_seen;
        int done_cyc;
        bit hs;
        int unsigned s_edge;
        longint dot;
        for (int k = 0; k < CB; k++) b_xh[k] = 32'((((k * 13) % 29) - 14) * 32768);
        for (int r = 0; r < RB; r++) b_bias[r] = 32'((((r * 7) % 19) - 9) * 4096);
        for (int r = 0; r < RB; r++) begin
            dot = 0;
            for (int k = 0; k < CB; k++) dot += longint'(wb(r, k)) * longint'(b_xh[k]);
            exp_b[r] = ref_row(dot, b_bias[r]);
        end
        rst_b = 1'b0;
        repeat (3) tick();
        rst_b = 1'b1;
        check("b_reset_busy", b_busy, 1'b0);
        check("b_reset_w_ready", b_w_ready, 1'b0);
        check("b_reset_done", b_done, 1'b0);
        check("b_reset_z0", b_z[0], 32'h0);

        done_seen = 0;
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        b_w_valid = 1'b1;
        idx = 0;
        guard = 0;
        while (idx < 1000 && guard < 1200) begin
            b_w_data = wb(idx / CB, idx % CB);
            hs = b_w_valid && (b_w_ready === 1'b1);
            tick();
            if (hs) idx++;
            if (b_done === 1'b1) done_seen++;
            guard++;
        end
        check("b_partial_words", idx, 1000);
        check("b_partial_z0", b_z[0], exp_b[0]);
        check("b_partial_z4", b_z[4], exp_b[4]);
        check("b_partial_z5", b_z[5], 32'h0);

        rst_b = 1'b0;
        tick();
        rst_b = 1'b1;
        check("b_rst_busy", b_busy, 1'b0);
        check("b_rst_w_ready", b_w_ready, 1'b0);
        check("b_rst_done", b_done, 1'b0);
        for (int r = 0; r < RB; r++) check($sformatf("b_rst_z[%0d]", r), b_z[r], 32'h0);
        repeat (20) begin
            tick();
            check("b_idle_done", b_done, 1'b0);
            check("b_idle_w_ready", b_w_ready, 1'b0);
        end

        b_start = 1'b1;
        tick();
        s_edge = edge_n;
        b_start = 1'b0;
        idx = 0;
        guard = 0;
        done_cyc = 0;
        while (guard < 81000) begin
            b_w_data = (idx < int'(RB * CB)) ? wb(idx / CB, idx % CB) : 32'($urandom);
            hs = b_w_valid && (b_w_ready === 1'b1);
            tick();
            if (hs) idx++;
            guard++;
            if (b_done === 1'b1) begin
                done_seen++;
                done_cyc = int'(edge_n - s_edge) + 2;
                break;
            end
        end
        check("b_full_words", idx, RB * CB);
        check("b_done_cycle", done_cyc, 80002);
        check("b_done_count", done_seen, 1);
        for (int r = 0; r < RB; r++) check($sformatf("b_z[%0d]", r), b_z[r], exp_b[r]);
        tick();
        check("b_after_done", b_done, 1'b0);
        check("b_after_busy", b_busy, 1'b0);
        check("b_after_w_ready", b_w_ready, 1'b0);
        b_w_valid = 1'b0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        fork
            run_small();
            run_big();
        join
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
